seq_detect: RTL
===============

Name: seq_detect

Overview:
- Serial-stream consumer placed directly downstream of the dff stage.
- Samples the registered bit q (here input din) on each enabled clock and detects a parameterised bit pattern, with overlapping matches allowed.
- Produces a one-cycle match pulse, a saturating match counter and an 8-bit history of accepted bits.
- Used in the lab datapath to check bit streams clocked through the dff.

Parameters:
PAT_W, 4, pattern length in bits (2..8)
PATTERN, 4'b1101, target pattern; MSB is the oldest bit, LSB is the newest
CNT_W, 8, match counter width

Ports:
clk  in  1  system clock, rising edge
clr  in  1  synchronous active-high reset
en  in  1  bit-valid strobe; din is accepted only when en=1
din  in  1  serial data bit (driven by dff q)
match  out  1  one-cycle pulse when the last PAT_W accepted bits equal PATTERN
match_cnt  out  CNT_W  number of matches since reset, saturating
cnt_sat  out  1  high while match_cnt equals its all-ones maximum
hist  out  8  last 8 accepted bits; bit 0 is the newest

Behaviour:
- Interface: one clock clk; reset clr is synchronous, active-high. Everything is sampled on the rising clk edge.
- Reset (clr=1 at an edge): window=0, fill=0, hist=0, match=0, match_cnt=0, cnt_sat=0, FSM=FILL.
- clr has priority over en. Reset mid-stream discards all partial progress; no match is issued at that edge.
- Accept: at an edge with en=1, clr=0:
  - window <= {window[PAT_W-2:0], din}
  - hist <= {hist[6:0], din}
  - fill increments, saturating at PAT_W.
- en=0: window, hist and fill hold; match <= 0.
- FSM states:
  - FILL: fill < PAT_W; matches are suppressed. This prevents false hits on reset zeros, e.g. PATTERN=0000.
  - RUN: fill == PAT_W.
  - FILL->RUN when the accepted bit makes fill reach PAT_W. RUN->FILL only on clr (or on a match when NONOVERLAP_EN is defined).
- Match is registered: match <= 1 at the accepting edge if the next-window value equals PATTERN and the next fill equals PAT_W. Latency: match is high for exactly the one cycle following the edge that accepted the final pattern bit.
- Overlap: the window is not cleared on match, so 1101101 gives two matches for PATTERN=1101.
- match_cnt increments by 1 in the same edge match is set, and holds at 2^CNT_W-1. cnt_sat = (match_cnt == all ones), registered together with match_cnt.
- Back-to-back en=1 cycles may produce match pulses on consecutive cycles. Each match is counted.

Optional Feature:
- Macro: SEQ_DETECT_NONOVERLAP_EN.
- Defined: on a match, fill resets to 0 and the FSM returns to FILL. window/hist still shift normally. The next match needs PAT_W fresh bits, so 1101101 gives one match.
- Undefined: overlapping detection as described above.

Decomposition:
- Shared package seq_pkg holds:
  - FSM state encoding constants: ST_FILL=1'b0, ST_RUN=1'b1
  - default PAT_W / PATTERN / CNT_W constants
  - HIST_W=8
- One sub-module is natural: bit_window (parameterised serial-in shift register with en and clr, width param). It is instantiated twice, for window (PAT_W) and hist (HIST_W).
- The FSM, fill counter, compare and counter stay in seq_detect.

Test Plan:
1. Basic match (PATTERN=1101): clr for 2 cycles, then en=1 with din 1,1,0,1 on consecutive edges -> match=1 for one cycle after the 4th edge; match_cnt=1; hist=8'h0D.
2. Overlap: stream 1,1,0,1,1,0,1 -> match pulses after bits 4 and 7; match_cnt=2. With SEQ_DETECT_NONOVERLAP_EN -> a single pulse after bit 4; match_cnt=1.
3. Enable gaps: 1,1,(en=0, din=0 for 3 cycles),0,1 -> gap cycles ignored; match after the final bit; match_cnt=1; hist=8'h0D.
4. Reset mid-operation: accept 1,1,0; assert clr for one edge; then accept 1 -> no match; match_cnt=0; hist=8'h01; FSM back in FILL.
5. Fill guard (PATTERN=4'b0000): after reset, accept 0,0,0 -> no match; 4th 0 -> match=1; a 5th 0 -> second match; match_cnt=2.
6. Saturation (CNT_W=4): feed 1101 repeatedly (overlapping) for 20 matches -> match_cnt stays 15 from the 15th match on; cnt_sat=1; match still pulses.

Source files
------------

// File: rtl/seq_pkg.sv
//------------------------------------------------------------------------------
// seq_pkg : shared constants and FSM state type for the seq_detect block.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package seq_pkg;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int         DEF_PAT_W   = 4;
   localparam logic [3:0] DEF_PATTERN = 4'b1101;
   localparam int         DEF_CNT_W   = 8;
   localparam int         HIST_W      = 8;

endpackage : seq_pkg

`default_nettype wire

// File: rtl/bit_window.sv
//------------------------------------------------------------------------------
// bit_window : serial-in shift register. The newest bit enters at bit 0.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bit_window #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en_i,
   input  logic             din_i,
   output logic [WIDTH-1:0] win_o
);

   logic [WIDTH-1:0] win_q;

   always_ff @(posedge clk) begin
      if (clr) begin
         win_q <= '0;
      end else if (en_i) begin
         win_q <= {win_q[WIDTH-2:0], din_i};
      end
   end

   assign win_o = win_q;

endmodule : bit_window

`default_nettype wire

// File: rtl/seq_detect.sv
//------------------------------------------------------------------------------
// seq_detect : serial pattern detector with match pulse, saturating counter
// and 8-bit history. Define SEQ_DETECT_NONOVERLAP_EN for non-overlapping hits.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seq_detect
   import seq_pkg::*;
#(
   parameter int               PAT_W   = DEF_PAT_W,
   parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
   parameter int               CNT_W   = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              en,
   input  logic              din,
   output logic              match,
   output logic [CNT_W-1:0]  match_cnt,
   output logic              cnt_sat,
   output logic [HIST_W-1:0] hist
);

   localparam int               FILL_W    = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

   logic [PAT_W-1:0]  w_win;
   logic [PAT_W-1:0]  w_win_next;
   logic              w_hit;

   state_t            state_q, state_d;
   logic [FILL_W-1:0] fill_q,  fill_d;
   logic              match_q, match_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic              sat_q,   sat_d;

   bit_window #(.WIDTH(PAT_W)) u_window (
      .clk   (clk),
      .clr   (clr),
      .en_i  (en),
      .din_i (din),
      .win_o (w_win)
   );

   bit_window #(.WIDTH(HIST_W)) u_hist (
      .clk   (clk),
      .clr   (clr),
      .en_i  (en),
      .din_i (din),
      .win_o (hist)
   );

   // Value the window takes at this edge if the bit is accepted.
   assign w_win_next = PAT_W'({w_win, din});

   always_comb begin
      state_d = state_q;
      fill_d  = fill_q;
      match_d = 1'b0;
      cnt_d   = cnt_q;
      sat_d   = sat_q;
      w_hit   = 1'b0;

      if (en) begin
         if (state_q == ST_FILL) begin
            fill_d  = fill_q + 1'b1;
            state_d = (fill_d == FILL_FULL) ? ST_RUN : ST_FILL;
         end

         // Hits only count once the window holds PAT_W real bits.
         w_hit = (fill_d == FILL_FULL) && (w_win_next == PATTERN);

         if (w_hit) begin
            match_d = 1'b1;
            if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
            sat_d = (cnt_d == '1);
`ifdef SEQ_DETECT_NONOVERLAP_EN
            fill_d  = '0;
            state_d = ST_FILL;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= ST_FILL;
         fill_q  <= '0;
         match_q <= 1'b0;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         match_q <= match_d;
         cnt_q   <= cnt_d;
         sat_q   <= sat_d;
      end
   end

   assign match     = match_q;
   assign match_cnt = cnt_q;
   assign cnt_sat   = sat_q;

endmodule : seq_detect

`default_nettype wire
